// File: rtl/y86_execute_stage_if.sv
// Y86-64 execute-stage bus: E pipeline-register inputs, forwarding outputs and M register outputs.
// The master drives the E-side inputs; the slave is the execute stage itself.
interface y86_execute_stage_if #(
    parameter int W = 64
);
    // Pipeline control and E-register contents
    logic         e_stall;
    logic         e_bubble;
    logic [1:0]   E_stat;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [W-1:0] E_valC;
    logic [W-1:0] E_valA;
    logic [W-1:0] E_valB;
    logic [3:0]   E_dstE;
    logic [3:0]   E_dstM;
    logic         m_exc;
    logic         W_exc;

    // Combinational forwarding back to decode
    logic [W-1:0] e_valE;
    logic [3:0]   e_dstE;
    logic         e_cnd;

    // Registered state
    logic [2:0]   cc;
    logic [1:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    modport master (
        output e_stall, e_bubble, E_stat, E_icode, E_ifun,
               E_valC, E_valA, E_valB, E_dstE, E_dstM, m_exc, W_exc,
        input  e_valE, e_dstE, e_cnd, cc,
               M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  e_stall, e_bubble, E_stat, E_icode, E_ifun,
               E_valC, E_valA, E_valB, E_dstE, E_dstM, m_exc, W_exc,
        output e_valE, e_dstE, e_cnd, cc,
               M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the E->M pipeline register.
// Optional EXEC_CC_EXC_MASK_EN: block CC updates while an older instruction in M or W has faulted.
module y86_execute_stage #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input logic               clk,
    input logic               rst_n,
    y86_execute_stage_if.slave bus
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [1:0] S_AOK    = 2'd0;
    localparam logic [2:0] CC_RESET = 3'b100;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_r;
    logic [3:0]   alu_fn;
    logic         flag_zf;
    logic         flag_sf;
    logic         flag_of;

    logic [2:0]   cc_q;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;
    logic         cond_true;
    logic         cnd;
    logic [3:0]   dst_e;
    logic         cc_mask;
    logic         cc_load;

    logic [1:0]   m_stat_q;
    logic [3:0]   m_icode_q;
    logic         m_cnd_q;
    logic [W-1:0] m_vale_q;
    logic [W-1:0] m_vala_q;
    logic [3:0]   m_dste_q;
    logic [3:0]   m_dstm_q;

    // Operand selection: stack ops adjust %rsp by 8, address ops add the displacement.
    always_comb begin
        alu_a = '0;
        case (bus.E_icode)
            I_CMOVXX, I_OPQ:            alu_a = bus.E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valC;
            I_CALL, I_PUSHQ:            alu_a = ~W'(7);
            I_RET, I_POPQ:              alu_a = W'(8);
            default:                    alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (bus.E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:     alu_b = bus.E_valB;
            default:                    alu_b = '0;
        endcase
    end

    assign alu_fn = (bus.E_icode == I_OPQ) ? bus.E_ifun : ALU_ADD;

    always_comb begin
        alu_r   = '0;
        flag_of = 1'b0;
        case (alu_fn)
            ALU_ADD: begin
                alu_r   = alu_b + alu_a;
                flag_of = (alu_a[W-1] == alu_b[W-1]) && (alu_r[W-1] != alu_b[W-1]);
            end
            ALU_SUB: begin
                alu_r   = alu_b - alu_a;
                flag_of = (alu_a[W-1] != alu_b[W-1]) && (alu_r[W-1] != alu_b[W-1]);
            end
            ALU_AND: alu_r = alu_b & alu_a;
            ALU_XOR: alu_r = alu_b ^ alu_a;
            default: alu_r = '0;
        endcase
    end

    assign flag_zf = (alu_r == '0);
    assign flag_sf = alu_r[W-1];

    // Conditions read the registered flags, i.e. the result of the previous OPq.
    assign cc_zf = cc_q[2];
    assign cc_sf = cc_q[1];
    assign cc_of = cc_q[0];

    always_comb begin
        cond_true = 1'b0;
        case (bus.E_ifun)
            4'h0:    cond_true = 1'b1;
            4'h1:    cond_true = (cc_sf ^ cc_of) | cc_zf;
            4'h2:    cond_true = cc_sf ^ cc_of;
            4'h3:    cond_true = cc_zf;
            4'h4:    cond_true = ~cc_zf;
            4'h5:    cond_true = ~(cc_sf ^ cc_of);
            4'h6:    cond_true = ~(cc_sf ^ cc_of) & ~cc_zf;
            default: cond_true = 1'b0;
        endcase
    end

    assign cnd   = ((bus.E_icode == I_CMOVXX) || (bus.E_icode == I_JXX)) && cond_true;
    assign dst_e = ((bus.E_icode == I_CMOVXX) && !cnd) ? RNONE : bus.E_dstE;

`ifdef EXEC_CC_EXC_MASK_EN
    assign cc_mask = bus.m_exc | bus.W_exc;
`else
    logic unused_exc;
    assign cc_mask    = 1'b0;
    assign unused_exc = bus.m_exc ^ bus.W_exc;
`endif

    assign cc_load = (bus.E_icode == I_OPQ) && (bus.E_stat == S_AOK) && !bus.e_stall && !cc_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= CC_RESET;
        end else if (cc_load) begin
            cc_q <= {flag_zf, flag_sf, flag_of};
        end
    end

    // Stall wins over bubble: with both asserted the M register simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stat_q  <= S_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else if (bus.e_stall) begin
            m_stat_q  <= m_stat_q;
            m_icode_q <= m_icode_q;
            m_cnd_q   <= m_cnd_q;
            m_vale_q  <= m_vale_q;
            m_vala_q  <= m_vala_q;
            m_dste_q  <= m_dste_q;
            m_dstm_q  <= m_dstm_q;
        end else if (bus.e_bubble) begin
            m_stat_q  <= S_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            m_stat_q  <= bus.E_stat;
            m_icode_q <= bus.E_icode;
            m_cnd_q   <= cnd;
            m_vale_q  <= alu_r;
            m_vala_q  <= bus.E_valA;
            m_dste_q  <= dst_e;
            m_dstm_q  <= bus.E_dstM;
        end
    end

    assign bus.e_valE  = alu_r;
    assign bus.e_dstE  = dst_e;
    assign bus.e_cnd   = cnd;
    assign bus.cc      = cc_q;
    assign bus.M_stat  = m_stat_q;
    assign bus.M_icode = m_icode_q;
    assign bus.M_cnd   = m_cnd_q;
    assign bus.M_valE  = m_vale_q;
    assign bus.M_valA  = m_vala_q;
    assign bus.M_dstE  = m_dste_q;
    assign bus.M_dstM  = m_dstm_q;
endmodule
